// File: rtl/ysyx_24080006_axi_rd_master_if.sv
// AXI read-channel bundle (AR + R) between the read initiator and the crossbar.
// Master drives address/control and rready; slave drives arready and the R beat.
interface ysyx_24080006_axi_rd_master_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/ysyx_24080006_axi_rd_master.sv
// AXI read initiator: core load/fetch request -> single-beat or INCR-burst AR/R, one-entry response buffer.
// Optional response timeout enabled by defining YSYX_24080006_AXI_RD_TIMEOUT_EN.
module ysyx_24080006_axi_rd_master #(
    parameter int         BURST_BEATS = 4,
    parameter logic [3:0] ARID        = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic        req_burst,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic        rsp_err,
    ysyx_24080006_axi_rd_master_if.master axi_r
);

    localparam int          LINE_BITS = $clog2(BURST_BEATS * 4);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_BITS) - 32'd1);
    localparam logic [7:0]  BURST_LEN = 8'(BURST_BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] araddr_reg, araddr_next;
    logic [7:0]  arlen_reg, arlen_next;
    logic [2:0]  arsize_reg, arsize_next;
    logic        arvalid_reg, arvalid_next;
    logic [7:0]  beat_cnt_reg, beat_cnt_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_data_reg, rsp_data_next;
    logic        rsp_last_reg, rsp_last_next;
    logic        rsp_err_reg, rsp_err_next;

    logic rready_c;
    logic ar_hs;
    logic r_hs;
    logic rsp_hs;
    logic beat_last;
    logic timeout_fire;

    // Buffer slot frees on the same edge the core drains it, so back-to-back beats need no bubble.
    assign rready_c  = (state_reg == S_R) && (!rsp_valid_reg || rsp_ready);
    assign ar_hs     = arvalid_reg && axi_r.arready;
    assign r_hs      = rready_c && axi_r.rvalid;
    assign rsp_hs    = rsp_valid_reg && rsp_ready;
    assign beat_last = (beat_cnt_reg == arlen_reg);

`ifdef YSYX_24080006_AXI_RD_TIMEOUT_EN
    logic [15:0] to_cnt_reg, to_cnt_next;

    // The counter only advances while actually waiting on the slave; core backpressure pauses it.
    always_comb begin
        to_cnt_next = 16'd0;
        case (state_reg)
            S_AR:    to_cnt_next = ar_hs ? 16'd0 : to_cnt_reg + 16'd1;
            S_R:     to_cnt_next = r_hs ? 16'd0 : (rready_c ? to_cnt_reg + 16'd1 : to_cnt_reg);
            default: to_cnt_next = 16'd0;
        endcase
    end

    assign timeout_fire = (to_cnt_reg == 16'hFFFF) &&
                          (((state_reg == S_AR) && !ar_hs) ||
                           (rready_c && !axi_r.rvalid));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_reg <= 16'd0;
        end else begin
            to_cnt_reg <= to_cnt_next;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        araddr_next    = araddr_reg;
        arlen_next     = arlen_reg;
        arsize_next    = arsize_reg;
        arvalid_next   = arvalid_reg;
        beat_cnt_next  = beat_cnt_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_last_next  = rsp_last_reg;
        rsp_err_next   = rsp_err_reg;

        if (rsp_hs) begin
            rsp_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_burst) begin
                        araddr_next = req_addr & LINE_MASK;
                        arlen_next  = BURST_LEN;
                        arsize_next = 3'b010;
                    end else begin
                        araddr_next = req_addr;
                        arlen_next  = 8'd0;
                        arsize_next = req_size;
                    end
                    arvalid_next = 1'b1;
                    state_next   = S_AR;
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    arvalid_next  = 1'b0;
                    beat_cnt_next = 8'd0;
                    state_next    = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    rsp_valid_next = 1'b1;
                    rsp_data_next  = axi_r.rdata;
                    rsp_last_next  = beat_last;
                    // The local beat count decides the end; a disagreeing rlast only flags the beat.
                    rsp_err_next   = (axi_r.rresp != 2'b00) || (axi_r.rlast != beat_last);
                    beat_cnt_next  = beat_cnt_reg + 8'd1;
                    if (beat_last) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (rsp_hs) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (timeout_fire) begin
            rsp_valid_next = 1'b1;
            rsp_data_next  = 32'hDEAD_BEEF;
            rsp_last_next  = 1'b1;
            rsp_err_next   = 1'b1;
            arvalid_next   = 1'b0;
            state_next     = S_DRAIN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            araddr_reg    <= 32'd0;
            arlen_reg     <= 8'd0;
            arsize_reg    <= 3'd0;
            arvalid_reg   <= 1'b0;
            beat_cnt_reg  <= 8'd0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            rsp_last_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            araddr_reg    <= araddr_next;
            arlen_reg     <= arlen_next;
            arsize_reg    <= arsize_next;
            arvalid_reg   <= arvalid_next;
            beat_cnt_reg  <= beat_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_last_reg  <= rsp_last_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign req_ready     = (state_reg == S_IDLE);
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_data      = rsp_data_reg;
    assign rsp_last      = rsp_last_reg;
    assign rsp_err       = rsp_err_reg;

    assign axi_r.arvalid = arvalid_reg;
    assign axi_r.araddr  = araddr_reg;
    assign axi_r.arid    = ARID;
    assign axi_r.arlen   = arlen_reg;
    assign axi_r.arsize  = arsize_reg;
    assign axi_r.arburst = 2'b01;
    assign axi_r.rready  = rready_c;

endmodule
